// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters with registered visible,
// sync and start-of-line/frame decode derived from the next position.
module video_timing #(
    parameter int H_VISIBLE        = 1024,
    parameter int H_FRONT          = 24,
    parameter int H_SYNC           = 136,
    parameter int H_BACK           = 160,
    parameter int V_VISIBLE        = 768,
    parameter int V_FRONT          = 3,
    parameter int V_SYNC           = 6,
    parameter int V_BACK           = 29,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        visible,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_bad_params
        $error("video_timing: illegal timing parameters");
    end

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    // Thresholds kept 32 bits wide so a boundary equal to 65536 cannot alias to 0.
    localparam logic [31:0] H_VIS_END  = 32'(H_VISIBLE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] H_SYNC_END = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] V_VIS_END  = 32'(V_VISIBLE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] V_SYNC_END = 32'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        visible_q, visible_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic        h_in_sync;
    logic        v_in_sync;

    // Next position and its decode; decoding the next value keeps the
    // registered flags aligned with the registered position.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        visible_d     = visible_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        x_ext         = 32'd0;
        y_ext         = 32'd0;
        h_in_sync     = 1'b0;
        v_in_sync     = 1'b0;

        if (ce) begin
            if (x_q == H_LAST) begin
                x_d          = 16'd0;
                line_start_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d           = 16'd0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 16'd1;
                end
            end else begin
                x_d = x_q + 16'd1;
            end

            x_ext     = {16'd0, x_d};
            y_ext     = {16'd0, y_d};
            h_in_sync = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
            v_in_sync = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);
            visible_d = (x_ext < H_VIS_END) && (y_ext < V_VIS_END);
            hsync_d   = h_in_sync ? SYNC_ON : ~SYNC_ON;
            vsync_d   = v_in_sync ? SYNC_ON : ~SYNC_ON;
        end
    end

    // State registers; reset parks on the last pixel so the first enabled
    // edge lands on (0,0) with both start pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            visible_q     <= 1'b0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign visible     = visible_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: three instances (default, medium, tiny timings)
// against a linear-pixel-index model, plus literal spot checks.
module tb_video_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] d_x, d_y, m_x, m_y, s_x, s_y;
    logic d_vis, d_hs, d_vs, d_ls, d_fs;
    logic m_vis, m_hs, m_vs, m_ls, m_fs;
    logic s_vis, s_hs, s_vs, s_ls, s_fs;

    video_timing dut_d (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(d_x), .y(d_y), .visible(d_vis),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
    );

    video_timing #(
        .H_VISIBLE(16), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_m (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(m_x), .y(m_y), .visible(m_vis),
        .hsync(m_hs), .vsync(m_vs), .line_start(m_ls), .frame_start(m_fs)
    );

    video_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(s_x), .y(s_y), .visible(s_vis),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
    );

    // Model: each instance is a single linear pixel index k in 0..N-1.
    localparam int ND = 1344 * 806;
    localparam int NM = 28 * 17;
    localparam int NS = 7 * 6;

    int  kd, km, ks;
    bit  adv;
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            kd = ND - 1;
            km = NM - 1;
            ks = NS - 1;
            adv = 1'b0;
            model_valid = 1'b1;
        end else if (ce) begin
            kd = (kd + 1) % ND;
            km = (km + 1) % NM;
            ks = (ks + 1) % NS;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
    end

    // Expected {x, y, visible, hsync, vsync, line_start, frame_start}.
    function automatic logic [36:0] expv(input int k, input bit a,
                                         input int hv, input int hf, input int hs, input int hb,
                                         input int vv, input int vf, input int vs,
                                         input bit ah);
        int ht, px, py;
        bit ha, va;
        ht = hv + hf + hs + hb;
        px = k % ht;
        py = k / ht;
        ha = (px >= hv + hf) && (px < hv + hf + hs);
        va = (py >= vv + vf) && (py < vv + vf + vs);
        return {16'(px), 16'(py), (px < hv) && (py < vv),
                ah ? ha : !ha, ah ? va : !va, a && (px == 0), a && (k == 0)};
    endfunction

    task automatic cmp_vec(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got x=%0d y=%0d vis/hs/vs/ls/fs=%b, expected x=%0d y=%0d vis/hs/vs/ls/fs=%b",
                     name, $time, act[36:21], act[20:5], act[4:0], exp[36:21], exp[20:5], exp[4:0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            cmp_vec("dut_d", {d_x, d_y, d_vis, d_hs, d_vs, d_ls, d_fs},
                    expv(kd, adv, 1024, 24, 136, 160, 768, 3, 6, 1'b0));
            cmp_vec("dut_m", {m_x, m_y, m_vis, m_hs, m_vs, m_ls, m_fs},
                    expv(km, adv, 16, 3, 4, 5, 10, 2, 3, 1'b0));
            cmp_vec("dut_s", {s_x, s_y, s_vis, s_hs, s_vs, s_ls, s_fs},
                    expv(ks, adv, 4, 1, 1, 1, 3, 1, 1, 1'b1));
        end
    end

    task automatic step(input logic r, input logic c);
        @(negedge clk);
        rst_n = r;
        ce    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;

        // Reset with random ce: must be ignored.
        step(1'b0, 1'($urandom));
        step(1'b0, 1'($urandom));
        chk("rst_d_x", d_x, 1343);
        chk("rst_d_y", d_y, 805);
        chk("rst_d_flags", {d_vis, d_hs, d_vs, d_ls, d_fs}, 5'b01100);
        chk("rst_s_xy", {s_x, s_y}, {16'd6, 16'd5});
        chk("rst_s_sync", {s_hs, s_vs}, 2'b00);

        // Continuous ce from reset release through one full default line.
        for (int n = 1; n <= 1345; n++) begin
            step(1'b1, 1'b1);
            if (n == 1) begin
                chk("first_d_xy", {d_x, d_y}, 0);
                chk("first_d_flags", {d_vis, d_ls, d_fs}, 3'b111);
            end
            if (n == 2) chk("second_d", {d_x, 13'd0, d_ls, d_fs}, {16'd1, 13'd0, 2'b00});
            if (n == 34) chk("s_sync_hi", {s_x, s_y, s_vis, s_hs, s_vs}, {16'd5, 16'd4, 3'b011});
            if (n == 43) chk("s_wrap", {s_x, s_y, s_fs, s_ls}, {32'd0, 2'b11});
            if (n == 336) chk("m_vs_before", m_vs, 1);
            if (n == 337) chk("m_vs_start", {m_y, m_vs}, {16'd12, 1'b0});
            if (n == 477) chk("m_frame", {m_x, m_y, m_fs}, {32'd0, 1'b1});
            if (n == 1024) chk("d_vis_last", {d_x, d_vis}, {16'd1023, 1'b1});
            if (n == 1025) chk("d_vis_fall", {d_x, d_vis}, {16'd1024, 1'b0});
            if (n == 1048) chk("d_hs_before", {d_x, d_hs}, {16'd1047, 1'b1});
            if (n == 1049) chk("d_hs_start", {d_x, d_hs}, {16'd1048, 1'b0});
            if (n == 1184) chk("d_hs_last", {d_x, d_hs}, {16'd1183, 1'b0});
            if (n == 1185) chk("d_hs_end", {d_x, d_hs}, {16'd1184, 1'b1});
            if (n == 1345) chk("d_line2", {d_x, d_y, d_ls, d_fs}, {16'd0, 16'd1, 2'b10});
        end

        // Alternating ce: position advances every other edge, pulses stay one clk wide.
        for (int n = 0; n < 200; n++) step(1'b1, 1'(n % 2 == 0));

        // Random enable with occasional reset of random length.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(299) == 0) begin
                for (int r = 0; r <= int'($urandom_range(2)); r++) step(1'b0, 1'($urandom));
            end else begin
                step(1'b1, 1'($urandom_range(9) < 7));
            end
        end

        // Reset while the medium instance sits inside both sync pulses.
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            step(1'b1, 1'b1);
            if (km % 28 == 20 && km / 28 == 13) found = 1'b1;
        end
        chk("m_reach_sync", int'(found), 1);
        if (found) begin
            chk("m_in_sync", {m_hs, m_vs}, 2'b00);
            step(1'b0, 1'b1);
            chk("m_rst_sync", {m_x, m_y, m_hs, m_vs, m_ls, m_fs}, {16'd27, 16'd16, 4'b1100});
            step(1'b1, 1'b0);
            chk("m_hold_ce0", {m_x, m_y, m_fs}, {16'd27, 16'd16, 1'b0});
            step(1'b1, 1'b1);
            chk("m_after_rst", {m_x, m_y, m_vis, m_ls, m_fs}, {32'd0, 3'b111});
        end

        step(1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
